// File: rtl/cc_sidecomparator_tracker_pkg.sv
// cc_sidecomparator_pkg: shared state/mode encodings and the matrix-build target default.
package cc_sidecomparator_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_QUAL = 2'b01, ST_HIT = 2'b10} state_e;
  typedef enum logic [1:0] {MODE_EQ = 2'b00, MODE_ANY = 2'b01, MODE_ALL = 2'b10, MODE_NONE = 2'b11} mode_e;
  localparam logic [7:0] TARGET_RESET_DEF = 8'b0001_0000;
endpackage

// File: rtl/cc_sidecomparator_tracker_if.sv
// cc_sidecomparator_tracker_if: compare-request and hit-status bundle between position bank and game FSM.
interface cc_sidecomparator_tracker_if #(
  parameter int DATAWIDTH = 8,
  parameter int CNT_WIDTH = 8
);
  logic [DATAWIDTH-1:0] SIDECMP_data_InBUS;
  logic [DATAWIDTH-1:0] SIDECMP_target_InBUS;
  logic [DATAWIDTH-1:0] SIDECMP_mask_InBUS;
  logic                 SIDECMP_load_InHigh;
  logic [1:0]           SIDECMP_mode_InBUS;
  logic                 SIDECMP_clear_InHigh;
  logic                 SIDECMP_match_OutHigh;
  logic                 SIDECMP_hit_OutHigh;
  logic [CNT_WIDTH-1:0] SIDECMP_hitcount_OutBUS;
  logic [1:0]           SIDECMP_state_OutBUS;
  modport master (
    output SIDECMP_data_InBUS, SIDECMP_target_InBUS, SIDECMP_mask_InBUS,
    output SIDECMP_load_InHigh, SIDECMP_mode_InBUS, SIDECMP_clear_InHigh,
    input  SIDECMP_match_OutHigh, SIDECMP_hit_OutHigh, SIDECMP_hitcount_OutBUS, SIDECMP_state_OutBUS
  );
  modport slave (
    input  SIDECMP_data_InBUS, SIDECMP_target_InBUS, SIDECMP_mask_InBUS,
    input  SIDECMP_load_InHigh, SIDECMP_mode_InBUS, SIDECMP_clear_InHigh,
    output SIDECMP_match_OutHigh, SIDECMP_hit_OutHigh, SIDECMP_hitcount_OutBUS, SIDECMP_state_OutBUS
  );
endinterface

// File: rtl/cc_sidecomparator_tracker_core.sv
// cc_sidecomparator_core: combinational masked compare of live data against the registered target.
module cc_sidecomparator_core
  import cc_sidecomparator_pkg::*;
#(
  parameter int DATAWIDTH = 8
) (
  input  logic [DATAWIDTH-1:0] data,
  input  logic [DATAWIDTH-1:0] target,
  input  logic [DATAWIDTH-1:0] mask,
  input  logic [1:0]           mode,
  output logic                 raw
);
  logic [DATAWIDTH-1:0] tm;
  logic [DATAWIDTH-1:0] common;
  always_comb begin
    tm     = target & mask;
    common = data & tm;
    raw    = mode == MODE_EQ  ? (data & mask) == tm :
             mode == MODE_ANY ? |common :
             mode == MODE_ALL ? common == tm : ~|common;
  end
endmodule

// File: rtl/cc_sidecomparator_tracker.sv
// cc_sidecomparator_tracker: qualifies a masked compare over HOLD_CYCLES edges, flags/pulses HIT, counts hits.
module cc_sidecomparator_tracker
  import cc_sidecomparator_pkg::*;
#(
  parameter int                   DATAWIDTH    = 8,
  parameter logic [DATAWIDTH-1:0] TARGET_RESET = DATAWIDTH'(TARGET_RESET_DEF),
  parameter int                   HOLD_CYCLES  = 2,
  parameter int                   CNT_WIDTH    = 8
) (
  input logic                          SIDECMP_CLOCK_50,
  input logic                          SIDECMP_RESET_InHigh,
  cc_sidecomparator_tracker_if.slave   sc
);
  localparam int QW = $clog2(HOLD_CYCLES + 1);
  state_e               state_q, state_d;
  logic [QW-1:0]        qcnt_q, qcnt_d;
  logic                 hit_q, hit_d, match_q, match_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATAWIDTH-1:0] target_q, target_d, mask_q, mask_d;
  logic                 raw;
  cc_sidecomparator_core #(.DATAWIDTH(DATAWIDTH)) u_core (
    .data   (sc.SIDECMP_data_InBUS),
    .target (target_q),
    .mask   (mask_q),
    .mode   (sc.SIDECMP_mode_InBUS),
    .raw    (raw)
  );
  always_comb begin
    state_d  = state_q;
    qcnt_d   = qcnt_q;
    hit_d    = 1'b0;
    target_d = sc.SIDECMP_load_InHigh ? sc.SIDECMP_target_InBUS : target_q;
    mask_d   = sc.SIDECMP_load_InHigh ? sc.SIDECMP_mask_InBUS : mask_q;
    if (sc.SIDECMP_load_InHigh) begin
      state_d = ST_IDLE;
      qcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (raw) begin
          if (HOLD_CYCLES == 1) begin
            state_d = ST_HIT;
            hit_d   = 1'b1;
          end else begin
            state_d = ST_QUAL;
            qcnt_d  = QW'(1);
          end
        end
        ST_QUAL: if (!raw) begin
          state_d = ST_IDLE;
          qcnt_d  = '0;
        end else if (qcnt_q + QW'(1) == QW'(HOLD_CYCLES)) begin
          state_d = ST_HIT;
          qcnt_d  = '0;
          hit_d   = 1'b1;
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
        ST_HIT: if (!raw) state_d = ST_IDLE;
        default: begin
          state_d = ST_IDLE;
          qcnt_d  = '0;
        end
      endcase
    end
    match_d = state_d == ST_HIT;
    // clear beats a simultaneous increment; the count sticks at all-ones
    cnt_d   = sc.SIDECMP_clear_InHigh ? '0 :
              (hit_d && cnt_q != '1) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
  end
  always_ff @(posedge SIDECMP_CLOCK_50) begin
    if (SIDECMP_RESET_InHigh) begin
      state_q  <= ST_IDLE;
      qcnt_q   <= '0;
      hit_q    <= 1'b0;
      match_q  <= 1'b0;
      cnt_q    <= '0;
      target_q <= TARGET_RESET;
      mask_q   <= '1;
    end else begin
      state_q  <= state_d;
      qcnt_q   <= qcnt_d;
      hit_q    <= hit_d;
      match_q  <= match_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      mask_q   <= mask_d;
    end
  end
  assign sc.SIDECMP_match_OutHigh   = match_q;
  assign sc.SIDECMP_hit_OutHigh     = hit_q;
  assign sc.SIDECMP_hitcount_OutBUS = cnt_q;
  assign sc.SIDECMP_state_OutBUS    = state_q;
endmodule

// File: tb/tb_cc_sidecomparator_tracker.sv
// tb_cc_sidecomparator_tracker: four parameter variants on shared stimulus, checked against a run-length model.
module tb_cc_sidecomparator_tracker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] d = '0, tg = '0, mk = '0;
  logic [1:0] md = '0;
  logic ld = 1'b0, clr = 1'b0;
  int checks = 0;
  int failures = 0;
  logic       o_m [4];
  logic       o_h [4];
  logic [7:0] o_c [4];
  logic [1:0] o_s [4];
  always #5 clk = ~clk;

  function automatic int hold_of(int i);
    return i == 2 ? 4 : i == 3 ? 1 : 2;
  endfunction
  function automatic int cmax_of(int i);
    return i == 1 ? 3 : 255;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : gi
    localparam int CW = g == 1 ? 2 : 8;
    localparam int HC = g == 2 ? 4 : g == 3 ? 1 : 2;
    cc_sidecomparator_tracker_if #(.DATAWIDTH(8), .CNT_WIDTH(CW)) bus ();
    assign bus.SIDECMP_data_InBUS   = d;
    assign bus.SIDECMP_target_InBUS = tg;
    assign bus.SIDECMP_mask_InBUS   = mk;
    assign bus.SIDECMP_load_InHigh  = ld;
    assign bus.SIDECMP_mode_InBUS   = md;
    assign bus.SIDECMP_clear_InHigh = clr;
    cc_sidecomparator_tracker #(
      .DATAWIDTH(8), .TARGET_RESET(8'h10), .HOLD_CYCLES(HC), .CNT_WIDTH(CW)
    ) dut (
      .SIDECMP_CLOCK_50     (clk),
      .SIDECMP_RESET_InHigh (rst),
      .sc                   (bus.slave)
    );
    assign o_m[g] = bus.SIDECMP_match_OutHigh;
    assign o_h[g] = bus.SIDECMP_hit_OutHigh;
    assign o_c[g] = 8'(bus.SIDECMP_hitcount_OutBUS);
    assign o_s[g] = bus.SIDECMP_state_OutBUS;
  end

  function automatic bit raw_of(logic [7:0] dd, logic [7:0] t, logic [7:0] m, logic [1:0] mo);
    case (mo)
      2'd0:    return (dd & m) == (t & m);
      2'd1:    return (dd & t & m) != 0;
      2'd2:    return (dd & t & m) == (t & m);
      default: return (dd & t & m) == 0;
    endcase
  endfunction

  task automatic cmp(string nm, int g, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[dut%0d] t=%0t got=%0h exp=%0h", nm, g, $time, act, exp);
    end
  endtask

  // Model: count consecutive raw-true edges since last reset/load/raw-false.
  logic [7:0] tr, mr;
  int run [4];
  int cnt [4];
  bit hm  [4];
  bit armed = 0;
  initial forever begin
    @(posedge clk);
    if (rst) begin
      tr = 8'h10;
      mr = 8'hFF;
      armed = 1;
      for (int i = 0; i < 4; i++) begin
        run[i] = 0;
        cnt[i] = 0;
        hm[i]  = 0;
      end
    end else if (armed) begin
      bit r;
      r = raw_of(d, tr, mr, md);
      if (ld) begin
        tr = tg;
        mr = mk;
      end
      for (int i = 0; i < 4; i++) begin
        run[i] = ld ? 0 : r ? (run[i] < 1000 ? run[i] + 1 : run[i]) : 0;
        hm[i]  = !ld && r && run[i] == hold_of(i);
        cnt[i] = clr ? 0 : (hm[i] && cnt[i] < cmax_of(i)) ? cnt[i] + 1 : cnt[i];
      end
    end
    #1;
    if (armed)
      for (int i = 0; i < 4; i++) begin
        cmp("model_match", i, o_m[i], run[i] >= hold_of(i));
        cmp("model_hit", i, o_h[i], hm[i]);
        cmp("model_count", i, o_c[i], cnt[i]);
        cmp("model_state", i, o_s[i], run[i] == 0 ? 0 : run[i] < hold_of(i) ? 1 : 2);
      end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tick(2);
    cmp("rst_match", 0, o_m[0], 0);
    cmp("rst_count", 0, o_c[0], 0);
    cmp("rst_state", 0, o_s[0], 0);
    rst = 1'b0;
    d = 8'h10;
    tick(1);
    cmp("eq_e1_state", 0, o_s[0], 1);
    cmp("eq_e1_hit", 0, o_h[0], 0);
    cmp("hold1_hit", 3, o_h[3], 1);
    tick(1);
    cmp("eq_e2_hit", 0, o_h[0], 1);
    cmp("eq_e2_match", 0, o_m[0], 1);
    cmp("eq_e2_count", 0, o_c[0], 1);
    cmp("eq_e2_state", 0, o_s[0], 2);
    tick(1);
    cmp("eq_e3_hit", 0, o_h[0], 0);
    cmp("eq_e3_match", 0, o_m[0], 1);
    d = 8'h00;
    tick(1);
    cmp("drop_state", 0, o_s[0], 0);
    d = 8'h10;
    tick(1);
    cmp("glitch_state", 0, o_s[0], 1);
    d = 8'h00;
    tick(1);
    cmp("glitch_idle", 0, o_s[0], 0);
    cmp("glitch_count", 0, o_c[0], 1);
    ld = 1'b1; tg = 8'h81; mk = 8'h80; md = 2'd2;
    tick(1);
    ld = 1'b0; d = 8'h83;
    tick(1);
    cmp("all_e1_state", 0, o_s[0], 1);
    tick(1);
    cmp("all_hit", 0, o_h[0], 1);
    cmp("all_count", 0, o_c[0], 2);
    ld = 1'b1;
    tick(1);
    cmp("load_in_hit_match", 0, o_m[0], 0);
    cmp("load_in_hit_state", 0, o_s[0], 0);
    tg = 8'h0F; mk = 8'hFF; md = 2'd1; d = 8'h08;
    tick(1);
    cmp("load_ignores_raw", 0, o_s[0], 0);
    ld = 1'b0;
    tick(2);
    cmp("any_match", 0, o_m[0], 1);
    cmp("any_count", 0, o_c[0], 3);
    md = 2'd3;
    tick(3);
    cmp("none_blocked", 0, o_s[0], 0);
    d = 8'hF0;
    tick(2);
    cmp("none_hit", 0, o_h[0], 1);
    cmp("count4", 0, o_c[0], 4);
    cmp("sat_count", 1, o_c[1], 3);
    d = 8'h08; tick(1); d = 8'hF0; tick(2);
    cmp("count5", 0, o_c[0], 5);
    cmp("sat_hold", 1, o_c[1], 3);
    d = 8'h08; tick(1); d = 8'hF0; tick(1);
    clr = 1'b1;
    tick(1);
    cmp("clr_hit", 1, o_h[1], 1);
    cmp("clr_count", 1, o_c[1], 0);
    cmp("clr_count0", 0, o_c[0], 0);
    cmp("clr_match", 0, o_m[0], 1);
    clr = 1'b0;
    d = 8'h08; tick(1); d = 8'hF0; tick(2);
    cmp("h4_qual", 2, o_s[2], 1);
    rst = 1'b1;
    tick(1);
    cmp("mid_rst_state", 2, o_s[2], 0);
    cmp("mid_rst_count", 2, o_c[2], 0);
    cmp("mid_rst_match", 2, o_m[2], 0);
    rst = 1'b0; md = 2'd0; d = 8'h10;
    tick(3);
    cmp("h4_e3_match", 2, o_m[2], 0);
    tick(1);
    cmp("h4_e4_hit", 2, o_h[2], 1);
    cmp("h4_e4_state", 2, o_s[2], 2);
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] pick;
      rst = $urandom_range(199) == 0;
      ld  = $urandom_range(15) == 0;
      clr = $urandom_range(31) == 0;
      if ($urandom_range(7) == 0) md = 2'($urandom);
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(4))
          0: pick = 8'h10;
          1: pick = 8'h0F;
          2: pick = 8'hF0;
          3: pick = 8'h81;
          default: pick = 8'($urandom);
        endcase
        d = pick;
      end
      tg = $urandom_range(1) ? 8'h10 : 8'($urandom);
      mk = $urandom_range(1) ? 8'hFF : 8'($urandom);
      tick(1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cc_sidecomparator_tracker.md
Name: cc_sidecomparator_tracker

Overview:
- Parametrised, registered successor to the fixed 8-bit bottom-side equality comparator used on the LED-matrix game datapath.
- Compares a row/position bus against a loadable target under a loadable mask and a selectable compare mode.
- Qualifies a match over HOLD_CYCLES consecutive clocks, then asserts a level flag and a one-cycle hit pulse, and counts hits.
- Sits between the position register bank and the game control FSM, replacing per-side hard-coded comparators.

Parameters:
- DATAWIDTH, 8: width of data, target and mask buses.
- TARGET_RESET, 8'b00010000 (DATAWIDTH bits): target value after reset.
- HOLD_CYCLES, 2: consecutive raw-match edges required before HIT. Legal range is 1..255.
- CNT_WIDTH, 8: hit counter width.

Ports:
- SIDECMP_CLOCK_50  in  1  system clock. All logic is on the rising edge.
- SIDECMP_RESET_InHigh  in  1  synchronous, active-high reset.
- SIDECMP_data_InBUS  in  DATAWIDTH  position/row data under test.
- SIDECMP_target_InBUS  in  DATAWIDTH  new target, captured on load.
- SIDECMP_mask_InBUS  in  DATAWIDTH  new mask, captured on load. 1 = bit compared.
- SIDECMP_load_InHigh  in  1  captures target and mask, and restarts qualification.
- SIDECMP_mode_InBUS  in  2  compare mode: 00 EQ, 01 ANY, 10 ALL, 11 NONE.
- SIDECMP_clear_InHigh  in  1  synchronous clear of the hit counter.
- SIDECMP_match_OutHigh  out  1  level: state is HIT.
- SIDECMP_hit_OutHigh  out  1  one-cycle pulse on entry to HIT.
- SIDECMP_hitcount_OutBUS  out  CNT_WIDTH  saturating hit count.
- SIDECMP_state_OutBUS  out  2  debug state: 00 IDLE, 01 QUAL, 10 HIT.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high. Reset has priority over every other input.
- Reset values:
  - target_r = TARGET_RESET; mask_r = all ones.
  - state = IDLE; qual count = 0.
  - match = 0; hit = 0; hitcount = 0; state out = 00.
- Raw compare is combinational on live data and registered target_r/mask_r. Let m = mask_r.
  - EQ: (data & m) == (target_r & m).
  - ANY: (data & target_r & m) != 0.
  - ALL: (data & target_r & m) == (target_r & m).
  - NONE: (data & target_r & m) == 0.
- Mode is a live input. A mode change simply alters raw and requalifies naturally.
- State machine, evaluated each edge when not in reset or load:
  - IDLE: raw=1 and HOLD_CYCLES=1 -> HIT. Raw=1 otherwise -> QUAL with qcnt=1. Raw=0 -> stay.
  - QUAL: raw=0 -> IDLE, qcnt=0. Raw=1 and qcnt+1 == HOLD_CYCLES -> HIT. Otherwise qcnt++.
  - HIT: raw=0 -> IDLE. Raw=1 -> stay. No further pulse is generated while in HIT.
- Latency: raw held high across N = HOLD_CYCLES consecutive edges gives match=1 and hit=1 registered after the Nth edge.
  - hit is high for exactly one cycle.
  - match falls after the first edge that samples raw=0.
- Load, when not in reset:
  - target_r/mask_r take the new values.
  - state = IDLE, qcnt = 0, match = 0, hit = 0.
  - Raw compare in the load cycle is ignored.
  - clear is still honoured in the same cycle.
- Counter:
  - Increments on the edge where hit is generated, i.e. on entry to HIT.
  - Saturates at 2^CNT_WIDTH-1.
  - clear in the same cycle as an increment gives 0 (clear wins).
  - clear does not affect state or match.
- Qual counter width is clog2(HOLD_CYCLES+1).
- All outputs are registered. No combinational path from input to output.

Decomposition:
- Shared package (cc_sidecomparator_pkg):
  - State encodings IDLE/QUAL/HIT.
  - Mode encodings MODE_EQ/ANY/ALL/NONE.
  - Default TARGET_RESET constant for the 8-bit matrix build.
- One natural sub-module: cc_sidecomparator_core, the purely combinational raw compare (data, target, mask, mode -> raw).
- The FSM, qualification counter and hit counter stay in the top module.

Test Plan:
- Reset defaults: DATAWIDTH=8, HOLD=2, mode EQ. Data=0x10 held 3 edges -> hit pulse after edge 2 only; match=1 from edge 2; hitcount=1; state 10.
- Glitch rejection: data=0x10 for 1 edge, then 0x00 -> state 01 then 00; match never 1; hitcount=0.
- Load/mask: load target=0x81, mask=0x80, mode ALL; data=0x83 for 2 edges -> HIT.
  - Load asserted again while in HIT -> match=0 next cycle, state 00.
- ANY/NONE: target=0x0F, mask=0xFF. data=0x08 in ANY -> HIT after 2 edges. Same data in NONE -> never HIT; data=0xF0 in NONE -> HIT.
- Counter: CNT_WIDTH=2; generate 5 hits -> hitcount saturates at 3. Clear on the cycle of the 6th hit pulse -> hitcount=0 and hit=1.
- Reset mid-qualification: HOLD=4, reset after 2 matching edges -> all outputs 0 next cycle; a further 4 matching edges are needed for HIT.
